// File: rtl/cpu_muldiv_pkg.sv
// Shared op codes, FSM state type and port ids for the mul/div arbiter.
package cpu_muldiv_pkg;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_MULH  = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_REM   = 3'd5;
    localparam logic [2:0] MD_REMU  = 3'd6;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Op codes 0..6 are defined; 7 is accepted but never reaches a unit.
    function automatic logic md_op_valid(input logic [2:0] op);
        return (op != 3'd7);
    endfunction

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/cpu_muldiv_rr_grant.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to prio.
module cpu_muldiv_rr_grant
    import cpu_muldiv_pkg::*;
(
    input  logic       i_a_valid,
    input  logic       i_b_valid,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    // One-hot grant: bit 0 = port A, bit 1 = port B.
    always_comb begin
        o_grant = '0;
        if (i_a_valid && i_b_valid) begin
            o_grant = (i_prio == PORT_B) ? 2'b10 : 2'b01;
        end else if (i_a_valid) begin
            o_grant = 2'b01;
        end else if (i_b_valid) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/cpu_muldiv_arbiter.sv
// Shares one multiply and one divide unit between ports A and B, counts the
// fixed unit latency and returns the selected result over a valid/ready handshake.
module cpu_muldiv_arbiter
    import cpu_muldiv_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 14
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_flush,

    input  logic        i_a_valid,
    input  logic [2:0]  i_a_op,
    input  logic [31:0] i_a_op1,
    input  logic [31:0] i_a_op2,
    output logic        o_a_ready,
    output logic        o_a_resp_valid,
    input  logic        i_a_resp_ready,
    output logic [31:0] o_a_resp_data,

    input  logic        i_b_valid,
    input  logic [2:0]  i_b_op,
    input  logic [31:0] i_b_op1,
    input  logic [31:0] i_b_op2,
    output logic        o_b_ready,
    output logic        o_b_resp_valid,
    input  logic        i_b_resp_ready,
    output logic [31:0] o_b_resp_data,

    output logic        o_unit_latch,
    output logic        o_unit_signed,
    output logic [31:0] o_unit_op1,
    output logic [31:0] o_unit_op2,
    input  logic [63:0] i_mul_result,
    input  logic [31:0] i_div_result,
    input  logic [31:0] i_div_remainder,

    output logic        o_busy
);

    localparam int unsigned MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1) + 1;

    state_t             r_state,          w_state_next;
    logic [CNT_W-1:0]   r_count,          w_count_next;
    logic               r_prio,           w_prio_next;
    logic               r_port,           w_port_next;
    logic [2:0]         r_op,             w_op_next;
    logic               r_a_ready,        w_a_ready_next;
    logic               r_b_ready,        w_b_ready_next;
    logic               r_a_resp_valid,   w_a_resp_valid_next;
    logic               r_b_resp_valid,   w_b_resp_valid_next;
    logic [31:0]        r_a_resp_data,    w_a_resp_data_next;
    logic [31:0]        r_b_resp_data,    w_b_resp_data_next;
    logic               r_unit_latch,     w_unit_latch_next;
    logic               r_unit_signed,    w_unit_signed_next;
    logic [31:0]        r_unit_op1,       w_unit_op1_next;
    logic [31:0]        r_unit_op2,       w_unit_op2_next;

    logic [1:0]         w_grant;
    logic [2:0]         w_sel_op;
    logic [31:0]        w_sel_op1;
    logic [31:0]        w_sel_op2;
    logic               w_done;
    logic [31:0]        w_result;
    logic               w_resp_ready;

    cpu_muldiv_rr_grant u_rr_grant (
        .i_a_valid (i_a_valid),
        .i_b_valid (i_b_valid),
        .i_prio    (r_prio),
        .o_grant   (w_grant)
    );

    // Request mux, latency-reached test and per-op result field selection.
    always_comb begin
        w_sel_op  = w_grant[1] ? i_b_op  : i_a_op;
        w_sel_op1 = w_grant[1] ? i_b_op1 : i_a_op1;
        w_sel_op2 = w_grant[1] ? i_b_op2 : i_a_op2;
        w_resp_ready = (r_port == PORT_B) ? i_b_resp_ready : i_a_resp_ready;
        if (md_is_mul(r_op)) begin
            w_done   = (r_count == CNT_W'(MUL_LATENCY));
            w_result = (r_op == MD_MUL) ? i_mul_result[31:0] : i_mul_result[63:32];
        end else begin
            w_done   = (r_count == CNT_W'(DIV_LATENCY));
            w_result = ((r_op == MD_DIV) || (r_op == MD_DIVU)) ? i_div_result : i_div_remainder;
        end
    end

    // Next-state and registered-output logic; flush outranks the response handshake.
    always_comb begin
        w_state_next        = r_state;
        w_count_next        = r_count;
        w_prio_next         = r_prio;
        w_port_next         = r_port;
        w_op_next           = r_op;
        w_a_ready_next      = 1'b0;
        w_b_ready_next      = 1'b0;
        w_unit_latch_next   = 1'b0;
        w_unit_signed_next  = r_unit_signed;
        w_unit_op1_next     = r_unit_op1;
        w_unit_op2_next     = r_unit_op2;
        w_a_resp_valid_next = r_a_resp_valid;
        w_b_resp_valid_next = r_b_resp_valid;
        w_a_resp_data_next  = r_a_resp_data;
        w_b_resp_data_next  = r_b_resp_data;

        unique case (r_state)
            IDLE: begin
                if (!i_flush && (w_grant != 2'b00)) begin
                    w_port_next     = w_grant[1] ? PORT_B : PORT_A;
                    w_op_next       = w_sel_op;
                    w_unit_op1_next = w_sel_op1;
                    w_unit_op2_next = w_sel_op2;
                    w_count_next    = '0;
                    if (w_grant[1]) begin
                        w_b_ready_next = 1'b1;
                    end else begin
                        w_a_ready_next = 1'b1;
                    end
                    if (md_op_valid(w_sel_op)) begin
                        w_unit_latch_next  = 1'b1;
                        w_unit_signed_next = md_is_signed(w_sel_op);
                        w_state_next       = RUN;
                    end else begin
                        // Undefined op: answer 0 without starting a unit.
                        w_unit_signed_next = 1'b0;
                        w_state_next       = RESP;
                        if (w_grant[1]) begin
                            w_b_resp_valid_next = 1'b1;
                            w_b_resp_data_next  = '0;
                        end else begin
                            w_a_resp_valid_next = 1'b1;
                            w_a_resp_data_next  = '0;
                        end
                    end
                end
            end
            RUN: begin
                if (i_flush) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else if (w_done) begin
                    w_state_next = RESP;
                    if (r_port == PORT_B) begin
                        w_b_resp_valid_next = 1'b1;
                        w_b_resp_data_next  = w_result;
                    end else begin
                        w_a_resp_valid_next = 1'b1;
                        w_a_resp_data_next  = w_result;
                    end
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            RESP: begin
                if (i_flush) begin
                    w_state_next        = IDLE;
                    w_a_resp_valid_next = 1'b0;
                    w_b_resp_valid_next = 1'b0;
                end else if (w_resp_ready) begin
                    w_state_next        = IDLE;
                    w_a_resp_valid_next = 1'b0;
                    w_b_resp_valid_next = 1'b0;
                    w_prio_next         = (r_port == PORT_A) ? PORT_B : PORT_A;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_prio         <= PORT_A;
            r_port         <= PORT_A;
            r_op           <= '0;
            r_a_ready      <= 1'b0;
            r_b_ready      <= 1'b0;
            r_a_resp_valid <= 1'b0;
            r_b_resp_valid <= 1'b0;
            r_a_resp_data  <= '0;
            r_b_resp_data  <= '0;
            r_unit_latch   <= 1'b0;
            r_unit_signed  <= 1'b0;
            r_unit_op1     <= '0;
            r_unit_op2     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_count        <= w_count_next;
            r_prio         <= w_prio_next;
            r_port         <= w_port_next;
            r_op           <= w_op_next;
            r_a_ready      <= w_a_ready_next;
            r_b_ready      <= w_b_ready_next;
            r_a_resp_valid <= w_a_resp_valid_next;
            r_b_resp_valid <= w_b_resp_valid_next;
            r_a_resp_data  <= w_a_resp_data_next;
            r_b_resp_data  <= w_b_resp_data_next;
            r_unit_latch   <= w_unit_latch_next;
            r_unit_signed  <= w_unit_signed_next;
            r_unit_op1     <= w_unit_op1_next;
            r_unit_op2     <= w_unit_op2_next;
        end
    end

    assign o_a_ready      = r_a_ready;
    assign o_b_ready      = r_b_ready;
    assign o_a_resp_valid = r_a_resp_valid;
    assign o_b_resp_valid = r_b_resp_valid;
    assign o_a_resp_data  = r_a_resp_data;
    assign o_b_resp_data  = r_b_resp_data;
    assign o_unit_latch   = r_unit_latch;
    assign o_unit_signed  = r_unit_signed;
    assign o_unit_op1     = r_unit_op1;
    assign o_unit_op2     = r_unit_op2;
    assign o_busy         = (r_state != IDLE);

endmodule
